gon_bus: RTL and testbench
==========================

// Module: gon_bus
// PURPOSE
//  Global output network (gather) bus: return path of the tag-multicast input bus.
//  Collects BITWIDTH results from NUM_SOURCES producers (PE rows/cols) into one
//  registered sink stream. Each source slot holds a scan-programmed tag ID; the
//  controller presents a tag, and the matching ready source's data is captured.
// PARAMETERS
//  BITWIDTH     16  data width per source and at the sink
//  TAG_LENGTH    4  width of tag / tag ID
//  NUM_SOURCES  10  number of source slots
// PORTS
//  clk               in   1                      clock
//  rstb              in   1                      synchronous reset, active-low
//  program           in   1                      1 = shift scan chain, block captures
//  scan_tag_in       in   TAG_LENGTH             scan chain input
//  scan_tag_next_bus out  TAG_LENGTH             scan chain output (= tag_id[0])
//  controller_enable in   1                      gather enabled
//  tag               in   TAG_LENGTH             requested source tag
//  source_value      in   BITWIDTH*NUM_SOURCES   slot k at [k*BITWIDTH +: BITWIDTH]
//  source_ready      in   NUM_SOURCES            slot k has valid data
//  source_ack        out  NUM_SOURCES            one-hot; slot k data consumed this cycle
//  output_value      out  BITWIDTH               registered gathered data
//  output_valid      out  1                      output_value valid
//  sink_ready        in   1                      sink accepts output_value this cycle
//  collision_err     out  1                      sticky multi-match flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rstb=0 at posedge): tag_id[*]=0, output_valid=0, output_value=0,
//    collision_err=0. source_ack is combinational and 0 while rstb=0.
//  - Scan: program=1 each posedge: tag_id[N-1]<=scan_tag_in, tag_id[k]<=tag_id[k+1].
//    First of N shifted values lands in slot 0. scan_tag_next_bus=tag_id[0].
//  - match[k] = controller_enable & ~program & source_ready[k] & (tag_id[k]==tag).
//  - sel = lowest k with match[k]; hit = |match.
//  - slot_free = ~output_valid | sink_ready.
//  - capture = hit & slot_free; source_ack = capture ? onehot(sel) : 0 (same cycle).
//  - Output register, 2-state (EMPTY/FULL = output_valid):
//    EMPTY: capture -> FULL, output_value<=source_value[sel].
//    FULL: sink_ready & capture -> stay FULL, load new data (full throughput).
//          sink_ready & ~capture -> EMPTY (output_value holds last data).
//          ~sink_ready -> hold; output_value stable; source_ack=0 (backpressure).
//  - Latency: source data at posedge N appears on output_value after posedge N.
//  - program asserted mid-operation: no new captures; FULL register drains normally.
//  - No match (unprogrammed tag or source not ready): no ack, state unchanged.
//  - Reset mid-transfer discards held data; no ack issued in reset cycle.
// CONFIGURATION
//  GON_COLLISION_DETECT_EN defined: collision_err set at posedge when
//    capture & popcount(match)>1; sticky until rstb=0. Lowest index still wins.
//  Not defined: collision_err tied to 0; no popcount logic.
// STRUCTURE
//  Shared package/header (shared with input bus): BITWIDTH, TAG_LENGTH defaults,
//  tag_t width constant, slot-slice helper macro.
//  Sub-module gon_slot (one per source, generate loop): tag_id_reg scan stage +
//  match compare; exposes tag_id_reg and match. Top holds priority encoder,
//  output register, collision logic.
// TESTING
//  1 Program: program=1, shift 12..0 over 13 cycles -> tag_id[0..9]=9..0? No:
//    last 10 values -> tag_id[k]=9-k... shift 9..0 -> tag_id[k]=9-k; scan_out=9.
//  2 Gather: tag_ids=0..9, source_ready=all1, slot3=13, tag=3, sink_ready=1 ->
//    source_ack=0x008 same cycle; next cycle output_value=13, output_valid=1.
//  3 Backpressure: FULL with 13, sink_ready=0, tag=1 (slot1=11) -> ack=0,
//    output_value stays 13; sink_ready=1 -> ack=0x002, next cycle 11.
//  4 Back-to-back: tags 3,1,9 on consecutive cycles, sink_ready=1 -> outputs 13,11,19
//    on consecutive cycles, acks 0x008,0x002,0x200.
//  5 Miss/program: tag=15 unprogrammed or program=1 -> no ack, output_valid drops
//    after sink accepts held data.
//  6 Collision (macro on): tag_id[2]=tag_id[5]=7, both ready, tag=7 -> ack=0x004,
//    collision_err=1 next cycle and sticky; macro off -> stays 0.

Source files
------------

// File: rtl/gon_bus_pkg.sv
// gon_bus_pkg: shared widths, output register states and slot-slice helper for the gather bus.
`define GON_SLOT(k, w) (k)*(w) +: (w)
package gon_bus_pkg;
  localparam int BITWIDTH    = 16;
  localparam int TAG_LENGTH  = 4;
  localparam int NUM_SOURCES = 10;
  typedef logic [TAG_LENGTH-1:0] tag_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/gon_bus_if.sv
// gon_bus_if: scan, source and sink signals of the gather bus; gon_bus sits on the slave modport.
interface gon_bus_if #(
  parameter int BITWIDTH    = gon_bus_pkg::BITWIDTH,
  parameter int TAG_LENGTH  = gon_bus_pkg::TAG_LENGTH,
  parameter int NUM_SOURCES = gon_bus_pkg::NUM_SOURCES
);
  logic                            prog;
  logic [TAG_LENGTH-1:0]           scan_tag_in;
  logic [TAG_LENGTH-1:0]           scan_tag_next_bus;
  logic                            controller_enable;
  logic [TAG_LENGTH-1:0]           tag;
  logic [BITWIDTH*NUM_SOURCES-1:0] source_value;
  logic [NUM_SOURCES-1:0]          source_ready;
  logic [NUM_SOURCES-1:0]          source_ack;
  logic [BITWIDTH-1:0]             output_value;
  logic                            output_valid;
  logic                            sink_ready;
  logic                            collision_err;
  modport master (
    output prog, scan_tag_in, controller_enable, tag, source_value, source_ready, sink_ready,
    input  scan_tag_next_bus, source_ack, output_value, output_valid, collision_err
  );
  modport slave (
    input  prog, scan_tag_in, controller_enable, tag, source_value, source_ready, sink_ready,
    output scan_tag_next_bus, source_ack, output_value, output_valid, collision_err
  );
endinterface

// File: rtl/gon_bus_slot.sv
// gon_slot: one scan-programmed tag ID stage plus its tag compare.
module gon_slot #(
  parameter int TAG_LENGTH = gon_bus_pkg::TAG_LENGTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  shift_i,
  input  logic                  en_i,
  input  logic [TAG_LENGTH-1:0] tag_in_i,
  input  logic [TAG_LENGTH-1:0] tag_i,
  output logic [TAG_LENGTH-1:0] tag_id_o,
  output logic                  match_o
);
  logic [TAG_LENGTH-1:0] tag_id_q, tag_id_d;
  always_comb tag_id_d = shift_i ? tag_in_i : tag_id_q;
  always_ff @(posedge clk) tag_id_q <= rstb ? tag_id_d : '0;
  assign tag_id_o = tag_id_q;
  assign match_o  = en_i & (tag_id_q == tag_i);
endmodule

// File: rtl/gon_bus.sv
// gon_bus: tag-matched gather of one source slot into a registered sink stream.
// Define GON_COLLISION_DETECT_EN for a sticky multi-match flag on collision_err.
module gon_bus
  import gon_bus_pkg::*;
#(
  parameter int BITWIDTH    = gon_bus_pkg::BITWIDTH,
  parameter int TAG_LENGTH  = gon_bus_pkg::TAG_LENGTH,
  parameter int NUM_SOURCES = gon_bus_pkg::NUM_SOURCES
) (
  input logic         clk,
  input logic         rstb,
  gon_bus_if.slave    bus
);
  logic [TAG_LENGTH-1:0]  chain [NUM_SOURCES+1];
  logic [NUM_SOURCES-1:0] match, first;
  logic [BITWIDTH-1:0]    sel_val, value_q, value_d;
  state_e                 state_q, state_d;
  logic                   en, hit, capture;
  assign chain[NUM_SOURCES]    = bus.scan_tag_in;
  assign bus.scan_tag_next_bus = chain[0];
  assign en = bus.controller_enable & ~bus.prog;
  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_slot
    gon_slot #(.TAG_LENGTH(TAG_LENGTH)) u_slot (
      .clk      (clk),
      .rstb     (rstb),
      .shift_i  (bus.prog),
      .en_i     (en & bus.source_ready[k]),
      .tag_in_i (chain[k+1]),
      .tag_i    (bus.tag),
      .tag_id_o (chain[k]),
      .match_o  (match[k])
    );
  end
  // isolate the lowest set match bit: fixed priority to the lowest slot index
  assign first   = match & (~match + 1'b1);
  assign hit     = |match;
  assign capture = hit & ((state_q == EMPTY) | bus.sink_ready);
  assign bus.source_ack = (rstb & capture) ? first : '0;
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      sel_val |= first[i] ? bus.source_value[`GON_SLOT(i, BITWIDTH)] : '0;
  end
  always_comb begin
    state_d = capture ? FULL : bus.sink_ready ? EMPTY : state_q;
    value_d = capture ? sel_val : value_q;
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= EMPTY;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
    end
  end
  assign bus.output_valid = (state_q == FULL);
  assign bus.output_value = value_q;
`ifdef GON_COLLISION_DETECT_EN
  logic col_q, col_d;
  always_comb col_d = col_q | (capture & |(match & (match - 1'b1)));
  always_ff @(posedge clk) col_q <= rstb ? col_d : 1'b0;
  assign bus.collision_err = col_q;
`else
  assign bus.collision_err = 1'b0;
`endif
endmodule

// File: tb/tb_gon_bus.sv
// tb_gon_bus: directed stimulus with a scoreboard queue of expected sink words.
module tb_gon_bus;
  logic clk = 1'b0;
  logic rstb;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
`ifdef GON_COLLISION_DETECT_EN
  localparam logic COL_EXP = 1'b1;
`else
  localparam logic COL_EXP = 1'b0;
`endif
  gon_bus_if #(.BITWIDTH(16), .TAG_LENGTH(4), .NUM_SOURCES(10)) bus ();
  gon_bus #(.BITWIDTH(16), .TAG_LENGTH(4), .NUM_SOURCES(10)) dut (.clk(clk), .rstb(rstb), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic [3:0] v);
    bus.prog = 1'b1;
    bus.scan_tag_in = v;
    #1 chk("ack_during_program", 32'(bus.source_ack), 0);
    tick();
  endtask
  task automatic gather(input logic [3:0] t, input logic [9:0] ack, input logic [15:0] val);
    bus.tag = t;
    #1 chk("ack_gather", 32'(bus.source_ack), 32'(ack));
    exp_q.push_back(val);
    tick();
  endtask
  // monitor: every accepted sink word is checked against the scoreboard
  always @(negedge clk) begin
    if (rstb && bus.output_valid && bus.sink_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected got %0h expected none", bus.output_value);
      end else chk("out_value", 32'(bus.output_value), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] col_tags [10];
    col_tags = '{4'd0, 4'd1, 4'd7, 4'd3, 4'd4, 4'd7, 4'd6, 4'd8, 4'd9, 4'd10};
    rstb = 1'b0;
    bus.prog = 1'b0;
    bus.scan_tag_in = '0;
    bus.controller_enable = 1'b1;
    bus.tag = '0;
    bus.source_ready = '1;
    bus.sink_ready = 1'b1;
    for (int k = 0; k < 10; k++) bus.source_value[k*16 +: 16] = 16'(10 + k);
    repeat (2) tick();
    chk("reset_ack", 32'(bus.source_ack), 0);
    chk("reset_valid", 32'(bus.output_valid), 0);
    chk("reset_value", 32'(bus.output_value), 0);
    chk("reset_col", 32'(bus.collision_err), 0);
    chk("reset_scan_out", 32'(bus.scan_tag_next_bus), 0);
    rstb = 1'b1;
    for (int v = 12; v >= 0; v--) shift(4'(v));
    bus.prog = 1'b0;
    bus.controller_enable = 1'b0;
    chk("scan_out_desc", 32'(bus.scan_tag_next_bus), 9);
    for (int v = 0; v < 10; v++) shift(4'(v));
    bus.prog = 1'b0;
    chk("scan_out_asc", 32'(bus.scan_tag_next_bus), 0);
    chk("valid_after_program", 32'(bus.output_valid), 0);
    bus.controller_enable = 1'b1;
    gather(4'd3, 10'h008, 16'd13);
    chk("valid_after_gather", 32'(bus.output_valid), 1);
    bus.sink_ready = 1'b0;
    bus.tag = 4'd1;
    #1 chk("ack_backpressure", 32'(bus.source_ack), 0);
    tick();
    chk("hold_value", 32'(bus.output_value), 13);
    chk("hold_ack", 32'(bus.source_ack), 0);
    tick();
    chk("hold_value2", 32'(bus.output_value), 13);
    chk("hold_valid", 32'(bus.output_valid), 1);
    bus.sink_ready = 1'b1;
    gather(4'd1, 10'h002, 16'd11);
    gather(4'd3, 10'h008, 16'd13);
    gather(4'd1, 10'h002, 16'd11);
    gather(4'd9, 10'h200, 16'd19);
    bus.tag = 4'd15;
    #1 chk("ack_miss", 32'(bus.source_ack), 0);
    tick();
    chk("valid_after_drain", 32'(bus.output_valid), 0);
    bus.tag = 4'd3;
    bus.source_ready[3] = 1'b0;
    #1 chk("ack_not_ready", 32'(bus.source_ack), 0);
    tick();
    chk("valid_not_ready", 32'(bus.output_valid), 0);
    bus.source_ready = '1;
    bus.prog = 1'b1;
    bus.scan_tag_in = 4'd3;
    #1 chk("ack_program_block", 32'(bus.source_ack), 0);
    tick();
    chk("valid_program_block", 32'(bus.output_valid), 0);
    bus.controller_enable = 1'b0;
    for (int k = 0; k < 10; k++) shift(col_tags[k]);
    bus.prog = 1'b0;
    chk("col_before", 32'(bus.collision_err), 0);
    bus.controller_enable = 1'b1;
    gather(4'd7, 10'h004, 16'd12);
    chk("col_set", 32'(bus.collision_err), 32'(COL_EXP));
    gather(4'd3, 10'h008, 16'd13);
    chk("col_sticky", 32'(bus.collision_err), 32'(COL_EXP));
    bus.tag = 4'd15;
    tick();
    chk("col_sticky2", 32'(bus.collision_err), 32'(COL_EXP));
    gather(4'd9, 10'h100, 16'd18);
    bus.sink_ready = 1'b0;
    bus.tag = 4'd15;
    tick();
    chk("full_before_reset", 32'(bus.output_valid), 1);
    rstb = 1'b0;
    bus.sink_ready = 1'b1;
    bus.tag = 4'd0;
    #1 chk("ack_in_reset", 32'(bus.source_ack), 0);
    tick();
    chk("valid_after_reset", 32'(bus.output_valid), 0);
    chk("value_after_reset", 32'(bus.output_value), 0);
    chk("col_after_reset", 32'(bus.collision_err), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    rstb = 1'b1;
    gather(4'd0, 10'h001, 16'd10);
    bus.tag = 4'd15;
    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
